// File: rtl/usb_transaction_controller.sv
// USB full-speed device transaction sequencer: token/data/handshake flow, per-endpoint DATA0/DATA1
// toggles and device address register. Define USB_STALL_EN to add a per-endpoint STALL input.
module usb_transaction_controller #(
    parameter int NUM_ENDPOINTS    = 4,
    parameter int RESPONSE_TIMEOUT = 80
) (
    input  logic                     clock48,
    input  logic                     reset_n,
    input  logic                     usb_reset,
    input  logic                     rx_token_valid,
    input  logic [3:0]               rx_token_pid,
    input  logic [6:0]               rx_token_addr,
    input  logic [3:0]               rx_token_endp,
    input  logic                     rx_data_valid,
    input  logic [3:0]               rx_data_pid,
    input  logic                     rx_data_crc_ok,
    input  logic                     rx_handshake_valid,
    input  logic [3:0]               rx_handshake_pid,
    output logic                     tx_start,
    output logic [3:0]               tx_pid,
    output logic                     tx_is_data,
    input  logic                     tx_done,
    input  logic [NUM_ENDPOINTS-1:0] in_armed,
    input  logic [NUM_ENDPOINTS-1:0] out_armed,
`ifdef USB_STALL_EN
    input  logic [NUM_ENDPOINTS-1:0] stall,
`endif
    output logic [3:0]               ep_index,
    output logic                     setup_complete,
    output logic                     out_complete,
    output logic                     in_complete,
    input  logic                     set_address,
    input  logic [6:0]               new_address,
    output logic [6:0]               device_address
);

    localparam int TW = $clog2(RESPONSE_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT = TW'(RESPONSE_TIMEOUT);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, SEND_HANDSHAKE, SEND_DATA, WAIT_ACK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    ep_q, ep_d;
    logic          is_setup_q, is_setup_d;
    logic [15:0]   in_tog_q, in_tog_d, out_tog_q, out_tog_d;
    logic [6:0]    dev_addr_q, dev_addr_d, pend_addr_q, pend_addr_d;
    logic          pend_q, pend_d;
    logic          tx_start_q, tx_start_d, tx_busy_q, tx_busy_d;
    logic [3:0]    tx_pid_q, tx_pid_d;
    logic          tx_is_data_q, tx_is_data_d;
    logic          setup_complete_q, setup_complete_d;
    logic          out_complete_q, out_complete_d;
    logic          in_complete_q, in_complete_d;

    logic [15:0]   in_armed_ep, out_armed_ep, stall_ep;
    logic          token_ok, send_pkt, pkt_is_data;
    logic [3:0]    pkt_pid;

    assign in_armed_ep  = 16'(in_armed);
    assign out_armed_ep = 16'(out_armed);
`ifdef USB_STALL_EN
    assign stall_ep     = 16'(stall);
`else
    assign stall_ep     = '0;
`endif

    // Tokens are never taken while our own packet is still on the wire.
    assign token_ok = rx_token_valid && !tx_busy_q
                   && (state_q == IDLE || state_q == WAIT_DATA)
                   && rx_token_addr == dev_addr_q
                   && int'(rx_token_endp) < NUM_ENDPOINTS
                   && (rx_token_pid == PID_SETUP || rx_token_pid == PID_OUT || rx_token_pid == PID_IN);

    always_comb begin
        // NOTE: every _d gets a default here so no path can infer a latch.
        state_d          = state_q;
        timer_d          = timer_q;
        ep_d             = ep_q;
        is_setup_d       = is_setup_q;
        in_tog_d         = in_tog_q;
        out_tog_d        = out_tog_q;
        dev_addr_d       = dev_addr_q;
        pend_addr_d      = pend_addr_q;
        pend_d           = pend_q;
        tx_start_d       = 1'b0;
        tx_pid_d         = tx_pid_q;
        tx_is_data_d     = tx_is_data_q;
        tx_busy_d        = tx_busy_q && !tx_done;
        setup_complete_d = 1'b0;
        out_complete_d   = 1'b0;
        in_complete_d    = 1'b0;
        send_pkt         = 1'b0;
        pkt_is_data      = 1'b0;
        pkt_pid          = PID_NAK;

        if (set_address) begin
            pend_d      = 1'b1;
            pend_addr_d = new_address;
        end

        if (token_ok) begin
            ep_d    = rx_token_endp;
            timer_d = '0;
            if (rx_token_pid == PID_IN) begin
                send_pkt = 1'b1;
                if (stall_ep[rx_token_endp]) begin
                    pkt_pid = PID_STALL;
                end else if (in_armed_ep[rx_token_endp]) begin
                    pkt_is_data = 1'b1;
                    pkt_pid     = in_tog_q[rx_token_endp] ? PID_DATA1 : PID_DATA0;
                end
            end else begin
                state_d    = WAIT_DATA;
                is_setup_d = (rx_token_pid == PID_SETUP);
            end
        end else begin
            case (state_q)
                WAIT_DATA: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TIMEOUT) begin
                        state_d = IDLE;
                    end else if (rx_data_valid) begin
                        state_d = IDLE;
                        if (rx_data_crc_ok && is_setup_q) begin
                            if (rx_data_pid == PID_DATA0) begin
                                send_pkt          = 1'b1;
                                pkt_pid           = PID_ACK;
                                in_tog_d[ep_q]    = 1'b1;
                                out_tog_d[ep_q]   = 1'b1;
                                setup_complete_d  = 1'b1;
                            end
                        end else if (rx_data_crc_ok && (rx_data_pid == PID_DATA0 || rx_data_pid == PID_DATA1)) begin
                            send_pkt = 1'b1;
                            pkt_pid  = PID_ACK;
                            if (stall_ep[ep_q]) begin
                                pkt_pid = PID_STALL;
                            end else if (rx_data_pid == (out_tog_q[ep_q] ? PID_DATA1 : PID_DATA0)) begin
                                if (out_armed_ep[ep_q]) begin
                                    out_tog_d[ep_q] = ~out_tog_q[ep_q];
                                    out_complete_d  = 1'b1;
                                end else begin
                                    pkt_pid = PID_NAK;
                                end
                            end
                        end
                    end
                end
                SEND_HANDSHAKE: if (tx_done) state_d = IDLE;
                SEND_DATA: begin
                    if (tx_done) begin
                        state_d = WAIT_ACK;
                        timer_d = '0;
                    end
                end
                WAIT_ACK: begin
                    timer_d = timer_q + TW'(1);
                    if (rx_handshake_valid) begin
                        state_d = IDLE;
                        if (rx_handshake_pid == PID_ACK) begin
                            in_tog_d[ep_q] = ~in_tog_q[ep_q];
                            in_complete_d  = 1'b1;
                            // A pending SET_ADDRESS lands only once its status stage is ACKed.
                            if (ep_q == 4'd0 && pend_q) begin
                                dev_addr_d = set_address ? new_address : pend_addr_q;
                                pend_d     = 1'b0;
                            end
                        end
                    end else if (rx_token_valid || rx_data_valid || timer_q == TIMEOUT) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (send_pkt) begin
            state_d      = pkt_is_data ? SEND_DATA : SEND_HANDSHAKE;
            tx_start_d   = 1'b1;
            tx_pid_d     = pkt_pid;
            tx_is_data_d = pkt_is_data;
            tx_busy_d    = 1'b1;
        end

        // Bus reset lets an in-flight packet finish but forgets everything else.
        if (usb_reset) begin
            state_d          = IDLE;
            timer_d          = '0;
            ep_d             = '0;
            in_tog_d         = '0;
            out_tog_d        = '0;
            dev_addr_d       = '0;
            pend_d           = 1'b0;
            tx_start_d       = 1'b0;
            tx_busy_d        = tx_busy_q && !tx_done;
            setup_complete_d = 1'b0;
            out_complete_d   = 1'b0;
            in_complete_d    = 1'b0;
            if (!tx_busy_q) begin
                tx_pid_d     = '0;
                tx_is_data_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            timer_q          <= '0;
            ep_q             <= '0;
            is_setup_q       <= 1'b0;
            in_tog_q         <= '0;
            out_tog_q        <= '0;
            dev_addr_q       <= '0;
            pend_addr_q      <= '0;
            pend_q           <= 1'b0;
            tx_start_q       <= 1'b0;
            tx_busy_q        <= 1'b0;
            tx_pid_q         <= '0;
            tx_is_data_q     <= 1'b0;
            setup_complete_q <= 1'b0;
            out_complete_q   <= 1'b0;
            in_complete_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            ep_q             <= ep_d;
            is_setup_q       <= is_setup_d;
            in_tog_q         <= in_tog_d;
            out_tog_q        <= out_tog_d;
            dev_addr_q       <= dev_addr_d;
            pend_addr_q      <= pend_addr_d;
            pend_q           <= pend_d;
            tx_start_q       <= tx_start_d;
            tx_busy_q        <= tx_busy_d;
            tx_pid_q         <= tx_pid_d;
            tx_is_data_q     <= tx_is_data_d;
            setup_complete_q <= setup_complete_d;
            out_complete_q   <= out_complete_d;
            in_complete_q    <= in_complete_d;
        end
    end

    assign tx_start       = tx_start_q;
    assign tx_pid         = tx_pid_q;
    assign tx_is_data     = tx_is_data_q;
    assign ep_index       = ep_q;
    assign setup_complete = setup_complete_q;
    assign out_complete   = out_complete_q;
    assign in_complete    = in_complete_q;
    assign device_address = dev_addr_q;

endmodule

// File: tb/tb_usb_transaction_controller.sv
// Self-checking bench for usb_transaction_controller: table of whole transactions plus
// hand-written address, timeout, bus-reset and async-reset sequences.
module tb_usb_transaction_controller;

    localparam int N = 4;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic         clock48 = 1'b0;
    logic         reset_n = 1'b0;
    logic         usb_reset = 1'b0;
    logic         rx_token_valid = 1'b0;
    logic [3:0]   rx_token_pid = '0;
    logic [6:0]   rx_token_addr = '0;
    logic [3:0]   rx_token_endp = '0;
    logic         rx_data_valid = 1'b0;
    logic [3:0]   rx_data_pid = '0;
    logic         rx_data_crc_ok = 1'b0;
    logic         rx_handshake_valid = 1'b0;
    logic [3:0]   rx_handshake_pid = '0;
    logic         tx_start;
    logic [3:0]   tx_pid;
    logic         tx_is_data;
    logic         tx_done = 1'b0;
    logic [N-1:0] in_armed = '0;
    logic [N-1:0] out_armed = '0;
`ifdef USB_STALL_EN
    logic [N-1:0] stall = '0;
`endif
    logic [3:0]   ep_index;
    logic         setup_complete, out_complete, in_complete;
    logic         set_address = 1'b0;
    logic [6:0]   new_address = '0;
    logic [6:0]   device_address;

    usb_transaction_controller #(.NUM_ENDPOINTS(N), .RESPONSE_TIMEOUT(80)) dut (
        .clock48(clock48), .reset_n(reset_n), .usb_reset(usb_reset),
        .rx_token_valid(rx_token_valid), .rx_token_pid(rx_token_pid),
        .rx_token_addr(rx_token_addr), .rx_token_endp(rx_token_endp),
        .rx_data_valid(rx_data_valid), .rx_data_pid(rx_data_pid), .rx_data_crc_ok(rx_data_crc_ok),
        .rx_handshake_valid(rx_handshake_valid), .rx_handshake_pid(rx_handshake_pid),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_is_data(tx_is_data), .tx_done(tx_done),
        .in_armed(in_armed), .out_armed(out_armed),
`ifdef USB_STALL_EN
        .stall(stall),
`endif
        .ep_index(ep_index), .setup_complete(setup_complete), .out_complete(out_complete),
        .in_complete(in_complete), .set_address(set_address), .new_address(new_address),
        .device_address(device_address)
    );

    always #10 clock48 = ~clock48;

    typedef struct {
        logic [3:0] tok_pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [3:0] data_pid;
        logic       crc_ok;
        logic       armed;
        logic [3:0] host_hs;
        logic       exp_tx;
        logic [3:0] exp_pid;
        logic       exp_is_data;
        logic       exp_setup;
        logic       exp_out;
        logic       exp_in;
        logic [3:0] exp_ep;
    } vec_t;

    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock48);
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        rx_token_pid = pid; rx_token_addr = addr; rx_token_endp = endp; rx_token_valid = 1'b1;
        tick();
        rx_token_valid = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] pid, input logic crc_ok);
        rx_data_pid = pid; rx_data_crc_ok = crc_ok; rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic send_hs(input logic [3:0] pid);
        rx_handshake_pid = pid; rx_handshake_valid = 1'b1;
        tick();
        rx_handshake_valid = 1'b0;
    endtask

    // Transmitter model: a few cycles on the wire, tx_pid must hold until tx_done.
    task automatic finish_tx(input string name, input logic [3:0] exp_pid);
        tick();
        check({name, " tx_start one-cycle"}, tx_start, 0);
        tick();
        tx_done = 1'b1;
        check({name, " tx_pid held"}, tx_pid, exp_pid);
        tick();
        tx_done = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        in_armed  = {N{v.armed}};
        out_armed = {N{v.armed}};
        send_token(v.tok_pid, v.addr, v.endp);
        if (v.tok_pid == PID_IN) begin
            check({nm, " tx_start"}, tx_start, v.exp_tx);
            if (v.exp_tx) begin
                check({nm, " tx_pid"}, tx_pid, v.exp_pid);
                check({nm, " tx_is_data"}, tx_is_data, v.exp_is_data);
            end
            if (tx_start) begin
                finish_tx(nm, v.exp_pid);
                if (v.exp_is_data) begin
                    repeat (2) tick();
                    send_hs(v.host_hs);
                    check({nm, " in_complete"}, in_complete, v.exp_in);
                end
            end
        end else begin
            check({nm, " no tx on token"}, tx_start, 0);
            repeat (2) tick();
            send_data(v.data_pid, v.crc_ok);
            check({nm, " tx_start"}, tx_start, v.exp_tx);
            check({nm, " setup_complete"}, setup_complete, v.exp_setup);
            check({nm, " out_complete"}, out_complete, v.exp_out);
            if (v.exp_tx) check({nm, " tx_pid"}, tx_pid, v.exp_pid);
            if (tx_start) finish_tx(nm, v.exp_pid);
        end
        check({nm, " ep_index"}, ep_index, v.exp_ep);
        repeat (3) tick();
    endtask

    initial begin
        //            tok        addr  ep    data       crc   arm   host     tx    pid        data  set   out   in    ep
        vecs[0]  = '{PID_SETUP, 7'd0, 4'd0, PID_DATA0, 1'b1, 1'b0, PID_ACK, 1'b1, PID_ACK,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{PID_OUT,   7'd0, 4'd1, PID_DATA0, 1'b1, 1'b0, PID_ACK, 1'b1, PID_NAK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[2]  = '{PID_OUT,   7'd0, 4'd1, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_ACK,   1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[3]  = '{PID_OUT,   7'd0, 4'd1, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[4]  = '{PID_OUT,   7'd0, 4'd1, PID_DATA1, 1'b1, 1'b1, PID_ACK, 1'b1, PID_ACK,   1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{PID_IN,    7'd0, 4'd2, PID_DATA0, 1'b1, 1'b0, PID_ACK, 1'b1, PID_NAK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[6]  = '{PID_IN,    7'd0, 4'd2, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_DATA0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[7]  = '{PID_IN,    7'd0, 4'd2, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_DATA1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[8]  = '{PID_SETUP, 7'd0, 4'd0, PID_DATA1, 1'b1, 1'b1, PID_ACK, 1'b0, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{PID_OUT,   7'd0, 4'd3, PID_DATA0, 1'b0, 1'b1, PID_ACK, 1'b0, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
        vecs[10] = '{PID_OUT,   7'd3, 4'd1, PID_DATA1, 1'b1, 1'b1, PID_ACK, 1'b0, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
        vecs[11] = '{PID_OUT,   7'd0, 4'd4, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b0, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
        vecs[12] = '{PID_IN,    7'd0, 4'd2, PID_DATA0, 1'b1, 1'b1, PID_NAK, 1'b1, PID_DATA0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[13] = '{PID_IN,    7'd0, 4'd2, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_DATA0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[14] = '{PID_SOF,   7'd0, 4'd0, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b0, PID_ACK,   1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        vecs[15] = '{PID_OUT,   7'd0, 4'd3, PID_DATA0, 1'b1, 1'b1, PID_ACK, 1'b1, PID_ACK,   1'b0, 1'b0, 1'b1, 1'b0, 4'd3};

        repeat (2) tick();
        check("reset tx_start", tx_start, 0);
        check("reset tx_pid", tx_pid, 0);
        check("reset tx_is_data", tx_is_data, 0);
        check("reset ep_index", ep_index, 0);
        check("reset completes", {setup_complete, out_complete, in_complete}, 0);
        check("reset device_address", device_address, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 16; i++) run_txn(vecs[i], i);

        // SET_ADDRESS: the new address appears only after the status-stage IN is ACKed.
        set_address = 1'b1; new_address = 7'd5;
        tick();
        set_address = 1'b0;
        in_armed = '1; out_armed = '1;
        send_token(PID_IN, 7'd0, 4'd0);
        check("addr status tx_start", tx_start, 1);
        check("addr status DATA1", tx_pid, PID_DATA1);
        finish_tx("addr status", PID_DATA1);
        check("addr before ack", device_address, 0);
        tick();
        send_hs(PID_ACK);
        check("addr in_complete", in_complete, 1);
        check("addr after ack", device_address, 5);
        tick();
        send_token(PID_OUT, 7'd0, 4'd1);
        repeat (2) tick();
        send_data(PID_DATA0, 1'b1);
        check("old addr ignored", tx_start, 0);
        repeat (3) tick();

        // IN with no host ACK: silent timeout, late ACK ignored, retry resends the same PID.
        send_token(PID_IN, 7'd5, 4'd2);
        check("in timeout DATA1", tx_pid, PID_DATA1);
        finish_tx("in timeout", PID_DATA1);
        repeat (100) tick();
        send_hs(PID_ACK);
        check("late ack ignored", in_complete, 0);
        tick();
        send_token(PID_IN, 7'd5, 4'd2);
        check("in retry tx_start", tx_start, 1);
        check("in retry same pid", tx_pid, PID_DATA1);
        finish_tx("in retry", PID_DATA1);
        tick();
        send_hs(PID_ACK);
        check("in retry in_complete", in_complete, 1);
        repeat (3) tick();

        // WAIT_DATA window: data at 70 clocks is accepted, data at 90 clocks is not.
        send_token(PID_OUT, 7'd5, 4'd1);
        repeat (70) tick();
        send_data(PID_DATA0, 1'b1);
        check("late-ok tx_start", tx_start, 1);
        check("late-ok ack", tx_pid, PID_ACK);
        check("late-ok out_complete", out_complete, 1);
        finish_tx("late-ok", PID_ACK);
        tick();
        send_token(PID_OUT, 7'd5, 4'd1);
        repeat (90) tick();
        send_data(PID_DATA1, 1'b1);
        check("data after timeout", tx_start, 0);
        repeat (3) tick();

        // Bus reset while waiting for the host ACK.
        send_token(PID_IN, 7'd5, 4'd2);
        check("busrst DATA0", tx_pid, PID_DATA0);
        finish_tx("busrst", PID_DATA0);
        tick();
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        check("busrst device_address", device_address, 0);
        check("busrst tx_start", tx_start, 0);
        check("busrst tx_pid", tx_pid, 0);
        check("busrst tx_is_data", tx_is_data, 0);
        check("busrst ep_index", ep_index, 0);
        check("busrst completes", {setup_complete, out_complete, in_complete}, 0);
        send_hs(PID_ACK);
        check("busrst ack ignored", in_complete, 0);
        tick();
        send_token(PID_OUT, 7'd0, 4'd1);
        repeat (2) tick();
        send_data(PID_DATA0, 1'b1);
        check("busrst toggle cleared tx", tx_start, 1);
        check("busrst toggle cleared complete", out_complete, 1);
        finish_tx("busrst out", PID_ACK);
        repeat (3) tick();

        // Async reset in the middle of an IN data transmission.
        send_token(PID_SETUP, 7'd0, 4'd0);
        repeat (2) tick();
        send_data(PID_DATA0, 1'b1);
        check("rstn setup_complete", setup_complete, 1);
        finish_tx("rstn setup", PID_ACK);
        tick();
        send_token(PID_IN, 7'd0, 4'd0);
        check("rstn in DATA1", tx_pid, PID_DATA1);
        tick();
        reset_n = 1'b0;
        tick();
        check("rstn outputs", {tx_start, tx_pid, tx_is_data, ep_index, setup_complete, out_complete, in_complete, device_address}, 0);
        reset_n = 1'b1;
        tick();
        send_token(PID_IN, 7'd0, 4'd0);
        check("rstn re-in tx_start", tx_start, 1);
        check("rstn re-in DATA0", tx_pid, PID_DATA0);
        finish_tx("rstn re-in", PID_DATA0);
        tick();
        send_hs(PID_ACK);
        check("rstn re-in in_complete", in_complete, 1);
        repeat (3) tick();

`ifdef USB_STALL_EN
        stall = 4'b0010;
        send_token(PID_IN, 7'd0, 4'd1);
        check("stall in pid", tx_pid, PID_STALL);
        check("stall in is_data", tx_is_data, 0);
        finish_tx("stall in", PID_STALL);
        tick();
        send_token(PID_OUT, 7'd0, 4'd1);
        repeat (2) tick();
        send_data(PID_DATA0, 1'b1);
        check("stall out pid", tx_pid, PID_STALL);
        check("stall out no complete", out_complete, 0);
        finish_tx("stall out", PID_STALL);
        tick();
        send_token(PID_SETUP, 7'd0, 4'd1);
        repeat (2) tick();
        send_data(PID_DATA0, 1'b1);
        check("stall setup ack", tx_pid, PID_ACK);
        check("stall setup complete", setup_complete, 1);
        finish_tx("stall setup", PID_ACK);
        stall = '0;
        repeat (3) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
